// File: rtl/rr_arbiter8.sv
// Eight-client round-robin arbiter with registered one-hot/indexed grant,
// a mandatory one-cycle gap between grants and an optional hold limit.
module rr_arbiter8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       preempt
);

  localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  localparam bit HOLD_EN = (MAX_HOLD != 0);

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  state_t          r_state, w_state;
  logic [7:0]      r_gnt, w_gnt;
  logic [2:0]      r_idx, w_idx;
  logic            r_valid, w_valid;
  logic            r_pre, w_pre;
  logic [2:0]      r_ptr, w_ptr;
  logic [HW-1:0]   r_hold, w_hold;
  logic [2:0]      w_sel;
  logic            w_hit;

  // Walk the search order backwards so the last hit is the first in priority.
  always_comb begin
    logic [2:0] cand;
    w_sel = 3'd0;
    w_hit = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      cand = r_ptr + 3'(k);
      if (req[cand]) begin
        w_sel = cand;
        w_hit = 1'b1;
      end
    end
  end

  always_comb begin
    w_state = r_state;
    w_gnt   = r_gnt;
    w_idx   = r_idx;
    w_valid = r_valid;
    w_pre   = 1'b0;
    w_ptr   = r_ptr;
    w_hold  = r_hold;
    case (r_state)
      BUSY: begin
        // Release wins over the hold limit when both happen together.
        if (!req[r_idx] || (HOLD_EN && r_hold == HOLD_MAX)) begin
          w_state = GAP;
          w_gnt   = 8'h00;
          w_idx   = 3'd0;
          w_valid = 1'b0;
          w_ptr   = r_idx + 3'd1;
          w_hold  = '0;
          w_pre   = req[r_idx];
        end else if (HOLD_EN) begin
          w_hold = r_hold + 1'b1;
        end
      end
      default: begin
        if (en && w_hit) begin
          w_state = BUSY;
          w_gnt   = 8'h01 << w_sel;
          w_idx   = w_sel;
          w_valid = 1'b1;
          w_hold  = HW'(1);
        end else begin
          w_state = IDLE;
          w_gnt   = 8'h00;
          w_idx   = 3'd0;
          w_valid = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gnt   <= 8'h00;
      r_idx   <= 3'd0;
      r_valid <= 1'b0;
      r_pre   <= 1'b0;
      r_ptr   <= 3'd0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state;
      r_gnt   <= w_gnt;
      r_idx   <= w_idx;
      r_valid <= w_valid;
      r_pre   <= w_pre;
      r_ptr   <= w_ptr;
      r_hold  <= w_hold;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_idx   = r_idx;
  assign gnt_valid = r_valid;
  assign preempt   = r_pre;

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Eight-requester round-robin arbiter that shares one downstream resource (a bus slot, a shared register port or a shared encoder/decoder unit) among eight clients. It grants exactly one requester at a time. The grant is driven both as a one-hot vector and as a 3-bit encoded index, so the same index can steer the shared datapath mux directly. A hold limit stops one client from monopolising the resource. All outputs are registered.

## Interface
- MAX_HOLD, 16, maximum consecutive cycles one grant may be held before forced preemption; 0 disables preemption
- clk  input  1  clock, rising-edge
- rst_n  input  1  asynchronous active-low reset
- en  input  1  arbitration enable; low blocks new grants only
- req  input  8  request per client, level-sensitive
- gnt  output  8  one-hot grant, registered
- gnt_idx  output  3  binary index of granted client; 3'b000 when gnt_valid=0
- gnt_valid  output  1  high while any grant is active (equals |gnt)
- preempt  output  1  one-cycle pulse in the cycle after a grant was forcibly removed

## Operation
- Reset values: state IDLE, gnt=8'h00, gnt_idx=3'b000, gnt_valid=0, preempt=0, priority pointer ptr=0, hold counter=0.
- ptr (3 bits) names the highest-priority client. Search order is ptr, ptr+1, …, ptr+7, taken mod 8.
- The grant is the first client in search order with req high. Only one client is granted at a time.
- IDLE:
  - If en=1 and req≠0, the selected client is granted and the state moves to BUSY. The hold counter loads 1.
  - Otherwise the block stays in IDLE.
- BUSY:
  - gnt, gnt_idx and gnt_valid are held steady.
  - The hold counter increments each cycle and saturates at MAX_HOLD.
  - en is ignored. Other requests are ignored.
- BUSY exit on release: when req[gnt_idx] is sampled low, the state moves to GAP, gnt clears, and ptr becomes gnt_idx+1 (mod 8, so 7 wraps to 0).
- BUSY exit on preemption: when MAX_HOLD≠0, the counter equals MAX_HOLD and req[gnt_idx] is still high, the state moves to GAP, gnt clears, ptr becomes gnt_idx+1 and preempt=1.
- GAP:
  - Exactly one cycle with no grant. preempt is high only during a GAP entered by preemption.
  - GAP arbitrates exactly as IDLE does: it grants directly into BUSY, or falls to IDLE if en=0 or req=0.
- A preempted client that keeps req high competes normally. It is granted again only if no other requester precedes it in the search order.
- A req that drops before it is granted is not remembered.
- Invariants: gnt is always one-hot or zero; gnt[gnt_idx]=gnt_valid; gnt_idx=0 whenever gnt_valid=0.
- Hold counter width is clog2(MAX_HOLD+1), with a minimum of 1 bit.

## Timing
- Grant latency: a request sampled at edge N while in IDLE or GAP (with en=1) gives gnt visible after edge N. That is one registered stage.
- Release latency: req[i] sampled low at edge N clears gnt after edge N.
- Turnaround between consecutive grants is exactly one dead cycle (GAP).
- Maximum grant length is MAX_HOLD cycles. A client holding req continuously with MAX_HOLD=4 sees gnt high for 4 cycles, then one GAP cycle with preempt=1.
- A release and the MAX_HOLD limit in the same cycle count as a release; preempt stays 0.
- en falling during BUSY has no effect. en low during IDLE or GAP produces no new grant.
- rst_n low clears all outputs immediately and asynchronously, including mid-grant. After rst_n rises, the first arbitration occurs at the next clock edge with ptr=0.
- No combinational path from inputs to outputs.

## Test plan
- Reset, then req=8'h01, en=1: one edge later gnt=8'h01, gnt_idx=0, gnt_valid=1. Drop req: gnt=0 next edge. GAP then IDLE.
- req=8'hFF, with each grantee dropping its req after 2 cycles: grant order is 0,1,2,…,7, with one zero cycle between grants. After 7 the order wraps to 0.
- MAX_HOLD=4, req=8'h08 held high: gnt=8'h08 for 4 cycles, then one cycle gnt=0 with preempt=1, then gnt=8'h08, gnt_idx=3 again.
- Wrap-around: after client 5 releases (ptr=6), req=8'h21 gives a grant to client 0 before client 5.
- en=0 with req=8'h10: no grant. en→1: gnt=8'h10, gnt_idx=4 after the next edge. en→0 during BUSY: the grant persists.
- rst_n pulsed low mid-grant of client 6: all outputs 0 without waiting for a clock edge. After release with req=8'hC1, client 0 is granted first.
